// File: rtl/ntt_stage_ctrl.sv
// Stage sequencer for the 4-bank mixed radix-2/4 NTT datapath: decodes the conf level,
// walks read/twiddle addresses per stage and replays them as write-backs BF_LAT cycles later.
module ntt_stage_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int R4_STAGES = 3,
  parameter int BF_LAT    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_conf,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W+1:0] o_tw_addr,
  output logic [1:0]        o_bf_mode,
  output logic [1:0]        o_stage,
  output logic              o_busy,
  output logic [1:0]        o_done_flag,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [ADDR_W-1:0] CNT_MAX    = {ADDR_W{1'b1}};
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(BF_LAT - 1);
  localparam logic [1:0]        LAST_R4    = 2'(R4_STAGES - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [1:0]          r_stage;
  logic [1:0]          r_cmd;
  logic [2:0]          r_last_conf;
  logic [DW-1:0]       r_drain;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W+1:0]   r_tw_addr;
  logic [1:0]          r_bf_mode;
  logic                r_busy;
  logic [1:0]          r_done_flag;
  logic [BF_LAT-1:0]   r_pipe_en;
  logic [ADDR_W-1:0]   r_pipe_addr [BF_LAT];

  logic                w_clear;
  logic                w_flush;
  logic [ADDR_W-1:0]   w_next_cnt;

  assign w_clear    = (i_conf == 3'd4);
  assign w_flush    = i_rst || w_clear;
  assign w_next_cnt = r_cnt + 1'b1;

  // Radix-4 stage s reads with the counter rotated left by 2*s bits; other modes read linearly.
  function automatic logic [ADDR_W-1:0] f_rd_addr(input logic [1:0] cmd, input logic [1:0] stg,
                                                  input logic [ADDR_W-1:0] c);
    logic [2*ADDR_W-1:0] w_dbl;
    w_dbl = {c, c} << {stg, 1'b0};
    return (cmd == 2'd1) ? w_dbl[2*ADDR_W-1:ADDR_W] : c;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_cmd       <= '0;
      r_last_conf <= '0;
      r_drain     <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_tw_addr   <= '0;
      r_bf_mode   <= '0;
      r_busy      <= 1'b0;
      r_done_flag <= '0;
    end else if (w_clear) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_last_conf <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done_flag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Level-triggered start: a held value never retriggers, only a change does.
          if ((i_conf inside {3'd1, 3'd2, 3'd3}) && (i_conf != r_last_conf)) begin
            r_state     <= RUN;
            r_cmd       <= i_conf[1:0];
            r_last_conf <= i_conf;
            r_done_flag <= '0;
            r_stage     <= '0;
            r_cnt       <= '0;
            r_rd_en     <= 1'b1;
            r_rd_addr   <= '0;
            r_tw_addr   <= '0;
            r_bf_mode   <= {i_conf == 3'd3, i_conf == 3'd1};
            r_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (r_cnt == CNT_MAX) begin
            r_state   <= DRAIN;
            r_cnt     <= '0;
            r_drain   <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
          end else begin
            r_cnt     <= w_next_cnt;
            r_rd_addr <= f_rd_addr(r_cmd, r_stage, w_next_cnt);
            r_tw_addr <= {r_stage, w_next_cnt};
          end
        end
        DRAIN: begin
          if (r_drain == DRAIN_LAST) r_state <= NEXT;
          else                       r_drain <= r_drain + 1'b1;
        end
        NEXT: begin
          if ((r_cmd == 2'd1) && (r_stage < LAST_R4)) begin
            r_state   <= RUN;
            r_stage   <= r_stage + 2'd1;
            r_cnt     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_tw_addr <= {r_stage + 2'd1, {ADDR_W{1'b0}}};
          end else begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_done_flag <= r_cmd;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back is the read stream delayed BF_LAT cycles, regardless of FSM state.
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_pipe_en <= '0;
      for (int i = 0; i < BF_LAT; i++) r_pipe_addr[i] <= '0;
    end else begin
      r_pipe_en[0]   <= r_rd_en;
      r_pipe_addr[0] <= r_rd_addr;
      for (int i = 1; i < BF_LAT; i++) begin
        r_pipe_en[i]   <= r_pipe_en[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_wr_en     = r_pipe_en[BF_LAT-1];
  assign o_wr_addr   = r_pipe_addr[BF_LAT-1];
  assign o_tw_addr   = r_tw_addr;
  assign o_bf_mode   = r_bf_mode;
  assign o_stage     = r_stage;
  assign o_busy      = r_busy;
  assign o_done_flag = r_done_flag;
  assign o_state     = r_state;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed bench for ntt_stage_ctrl at default parameters: full passes against a cycle model,
// held-level / clear / reset behaviour with hand-computed values.
module tb_ntt_stage_ctrl;

  localparam int NW  = 64;
  localparam int LAT = 4;
  localparam int SC  = NW + LAT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] conf;
  logic       rd_en, wr_en, busy;
  logic [5:0] rd_addr, wr_addr;
  logic [7:0] tw_addr;
  logic [1:0] bf_mode, stage, done_flag;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  ntt_stage_ctrl #(.ADDR_W(6), .R4_STAGES(3), .BF_LAT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_conf(conf),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
    .o_tw_addr(tw_addr), .o_bf_mode(bf_mode), .o_stage(stage), .o_busy(busy),
    .o_done_flag(done_flag), .o_state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rotl(input logic [5:0] c, input int sh);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[(i + sh) % 6] = c[i];
    return r;
  endfunction

  // Expected read side t cycles after the start edge (state: 0 idle,1 run,2 drain,3 next,4 done).
  function automatic void model(input int t, input int nst, input logic [2:0] cmd,
                                output logic en, output logic [5:0] addr, output logic [7:0] tw,
                                output logic [1:0] stg, output logic [2:0] st);
    int p, off;
    en = 1'b0; addr = '0; tw = '0; stg = '0; st = 3'd0;
    if (t >= 0) begin
      if (t < nst * SC) begin
        p = t / SC; off = t % SC; stg = 2'(p);
        if (off < NW) begin
          en = 1'b1; st = 3'd1;
          addr = (cmd == 3'd1) ? rotl(6'(off), 2 * p) : 6'(off);
          tw = {2'(p), 6'(off)};
        end else if (off < NW + LAT) st = 3'd2;
        else st = 3'd3;
      end else begin
        stg = 2'(nst - 1);
        st = (t == nst * SC) ? 3'd4 : 3'd0;
      end
    end
  endfunction

  task automatic run_pass(input logic [2:0] cmd, input int nst);
    logic e_en, w_en;
    logic [5:0] e_addr, w_addr;
    logic [7:0] e_tw, w_tw;
    logic [1:0] e_stg, w_stg, e_mode, e_done;
    logic [2:0] e_st, w_st;
    int t_done, wr_cnt;
    t_done = nst * SC;
    wr_cnt = 0;
    e_mode = (cmd == 3'd1) ? 2'd1 : (cmd == 3'd2) ? 2'd0 : 2'd2;
    conf = cmd;
    for (int t = 0; t <= t_done + 1; t++) begin
      @(negedge clk);
      model(t, nst, cmd, e_en, e_addr, e_tw, e_stg, e_st);
      model(t - LAT, nst, cmd, w_en, w_addr, w_tw, w_stg, w_st);
      e_done = (t > t_done) ? cmd[1:0] : 2'b00;
      if (wr_en === 1'b1) wr_cnt++;
      n_vec++;
      if (rd_en !== e_en) begin n_err++; $display("FAIL pass%0d t=%0d rd_en got %b exp %b", cmd, t, rd_en, e_en); end
      if (e_en) begin
        n_vec++;
        if (rd_addr !== e_addr) begin n_err++; $display("FAIL pass%0d t=%0d rd_addr got %0d exp %0d", cmd, t, rd_addr, e_addr); end
        n_vec++;
        if (tw_addr !== e_tw) begin n_err++; $display("FAIL pass%0d t=%0d tw_addr got %h exp %h", cmd, t, tw_addr, e_tw); end
      end
      n_vec++;
      if (wr_en !== w_en) begin n_err++; $display("FAIL pass%0d t=%0d wr_en got %b exp %b", cmd, t, wr_en, w_en); end
      if (w_en) begin
        n_vec++;
        if (wr_addr !== w_addr) begin n_err++; $display("FAIL pass%0d t=%0d wr_addr got %0d exp %0d", cmd, t, wr_addr, w_addr); end
      end
      n_vec++;
      if (stage !== e_stg) begin n_err++; $display("FAIL pass%0d t=%0d stage got %0d exp %0d", cmd, t, stage, e_stg); end
      n_vec++;
      if (state !== e_st) begin n_err++; $display("FAIL pass%0d t=%0d state got %0d exp %0d", cmd, t, state, e_st); end
      n_vec++;
      if (busy !== (e_st != 3'd0)) begin n_err++; $display("FAIL pass%0d t=%0d busy got %b exp %b", cmd, t, busy, e_st != 3'd0); end
      n_vec++;
      if (bf_mode !== e_mode) begin n_err++; $display("FAIL pass%0d t=%0d bf_mode got %0d exp %0d", cmd, t, bf_mode, e_mode); end
      n_vec++;
      if (done_flag !== e_done) begin n_err++; $display("FAIL pass%0d t=%0d done_flag got %b exp %b", cmd, t, done_flag, e_done); end
    end
    n_vec++;
    if (wr_cnt != nst * NW) begin n_err++; $display("FAIL pass%0d wr_count got %0d exp %0d", cmd, wr_cnt, nst * NW); end
  endtask

  task automatic test_reset();
    rst = 1'b1; conf = 3'd0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({rd_en, rd_addr, wr_en, wr_addr, tw_addr, bf_mode, stage, busy, done_flag} !== 32'd0) begin
      n_err++; $display("FAIL reset outputs got %h exp 0",
                        {rd_en, rd_addr, wr_en, wr_addr, tw_addr, bf_mode, stage, busy, done_flag});
    end
    n_vec++;
    if (state !== 3'd0) begin n_err++; $display("FAIL reset state got %0d exp 0", state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_r4_pass();
    run_pass(3'd1, 3);
  endtask

  task automatic test_sequence();
    run_pass(3'd3, 1);
    run_pass(3'd2, 1);
  endtask

  task automatic test_hold_and_clear();
    run_pass(3'd1, 3);
    for (int i = 0; i < 113; i++) begin
      conf = (i >= 100 && i < 103) ? 3'd0 : 3'd1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done_flag !== 2'b01) begin
        n_err++; $display("FAIL hold_no_restart i=%0d busy got %b done got %b exp 0/01", i, busy, done_flag);
      end
    end
    conf = 3'd4;
    @(negedge clk);
    n_vec++;
    if (done_flag !== 2'b00 || busy !== 1'b0 || state !== 3'd0) begin
      n_err++; $display("FAIL clear_idle done got %b busy %b state %0d exp 00/0/0", done_flag, busy, state);
    end
    run_pass(3'd1, 3);
  endtask

  task automatic test_clear_mid();
    conf = 3'd4;
    @(negedge clk);
    conf = 3'd1;
    repeat (SC + 21) @(negedge clk);
    n_vec++;
    if (stage !== 2'd1 || rd_addr !== 6'd17 || tw_addr !== 8'h54) begin
      n_err++; $display("FAIL clear_mid_pre stage %0d rd_addr %0d tw %h exp 1/17/54", stage, rd_addr, tw_addr);
    end
    conf = 3'd4;
    @(negedge clk);
    n_vec++;
    if (state !== 3'd0 || rd_en !== 1'b0 || wr_en !== 1'b0 || done_flag !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL clear_mid state %0d rd_en %b wr_en %b done %b busy %b exp 0/0/0/00/0",
                        state, rd_en, wr_en, done_flag, busy);
    end
    repeat (8) begin
      @(negedge clk);
      n_vec++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
        n_err++; $display("FAIL clear_mid_after rd_en %b wr_en %b exp 0/0", rd_en, wr_en);
      end
    end
    conf = 3'd0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    conf = 3'd1;
    repeat (31) @(negedge clk);
    n_vec++;
    if (rd_en !== 1'b1 || rd_addr !== 6'd30) begin
      n_err++; $display("FAIL reset_mid_pre rd_en %b rd_addr %0d exp 1/30", rd_en, rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({rd_en, rd_addr, wr_en, wr_addr, tw_addr, bf_mode, stage, busy, done_flag, state} !== 35'd0) begin
      n_err++; $display("FAIL reset_mid outputs got %h exp 0",
                        {rd_en, rd_addr, wr_en, wr_addr, tw_addr, bf_mode, stage, busy, done_flag, state});
    end
    repeat (6) begin
      @(negedge clk);
      n_vec++;
      if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_mid_wr wr_en got %b exp 0", wr_en); end
    end
    rst = 1'b0;
    run_pass(3'd1, 3);
  endtask

  initial begin
    test_reset();
    test_r4_pass();
    test_sequence();
    test_hold_and_clear();
    test_clear_mid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequencer for the 4-bank mixed radix-2/4 NTT datapath under top_stage.
- Decodes the 3-bit conf command and runs the requested pass: radix-4 stages, one radix-2 stage, or a scaling pass.
- Drives the shared read/write addresses for all four banks, the twiddle address and the butterfly mode.
- Reports completion through done_flag.

Parameters:
ADDR_W, 6, per-bank address width (2^ADDR_W words per bank, N = 4*2^ADDR_W)
R4_STAGES, 3, radix-4 stages run by conf=1 (must be <= ADDR_W/2 and <= 4)
BF_LAT, 4, butterfly pipeline latency in cycles, read issue to write-back (>= 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
conf  in  3  command level: 0 nop, 1 radix-4 pass, 2 radix-2 pass, 3 scale pass, 4 clear, 5-7 nop
rd_en  out  1  read strobe, common to banks 0-3
rd_addr  out  ADDR_W  read address, common to banks 0-3
wr_en  out  1  write-back strobe, common to banks 0-3
wr_addr  out  ADDR_W  write-back address
tw_addr  out  ADDR_W+2  twiddle ROM address, {stage, cnt}
bf_mode  out  2  0 radix-2, 1 radix-4, 2 scale, 3 unused
stage  out  2  current stage index
busy  out  1  high in any state other than IDLE
done_flag  out  2  00 none/busy, 01 conf1 done, 10 conf2 done, 11 conf3 done

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; cnt=0; stage=0; last_conf=0.
  - All outputs 0; the write-delay pipeline is flushed.
  - Reset mid-pass aborts with no further wr_en.
- States: IDLE, RUN, DRAIN, NEXT, DONE.
- IDLE:
  - Start when conf is in {1,2,3} and conf != last_conf.
  - On start: latch cmd=conf, last_conf=conf, done_flag=00, stage=0, cnt=0; go to RUN.
  - A level held at the same value never restarts.
  - conf=0 or 5-7: no action, last_conf unchanged.
- RUN: rd_en=1 every cycle.
  - cmd=1: bf_mode=1; rd_addr = cnt rotated left by 2*stage bits within ADDR_W.
  - cmd=2: bf_mode=0; rd_addr=cnt.
  - cmd=3: bf_mode=2; rd_addr=cnt.
  - tw_addr={stage,cnt} in all modes.
  - cnt increments each cycle. When cnt=2^ADDR_W-1: cnt wraps to 0, rd_en is 0 from the next cycle, go to DRAIN.
- Write-back:
  - wr_en and wr_addr are rd_en and rd_addr delayed by exactly BF_LAT cycles through a shift register.
  - This holds independently of state.
- DRAIN: counts BF_LAT cycles, then goes to NEXT. The last write-back occurs in the final DRAIN cycle.
  - Reads of a new stage never overlap write-backs of the previous stage, so there is no read/write address hazard.
- NEXT (1 cycle):
  - If cmd=1 and stage < R4_STAGES-1: stage++, go to RUN.
  - Otherwise go to DONE.
- DONE (1 cycle):
  - done_flag = cmd[1:0] (01/10/11); go to IDLE.
  - done_flag holds until the next start, a clear, or reset.
  - bf_mode and stage hold their last values in IDLE until the next start.
- Per-stage cost: 2^ADDR_W + BF_LAT + 1 cycles (69 at defaults).
- Pass totals at defaults, from the start edge to the done_flag edge:
  - conf=1: 3*69+1 = 208 cycles.
  - conf=2 and conf=3: 70 cycles each.
- conf=4 (clear):
  - From any state: next cycle state=IDLE, rd_en=0, pipeline flushed (wr_en=0), done_flag=00, last_conf=0.
  - The same command value may then be issued again.
- conf change during RUN, DRAIN or NEXT (other than to 4) is ignored.
  - last_conf is already set, so the new value starts only if it is still present in IDLE and differs.
- done_flag is registered; busy is registered (state != IDLE).

Test Plan:
- Reset then conf=1 held → RUN stage 0 rd_addr 0..63; stage 1 rd_addr=rotl2(cnt) (cnt=1→4, cnt=16→1); stage 2 rotl4 (cnt=1→16); done_flag=01 exactly 208 cycles after start; a single pulse of DONE.
- Check wr_en/wr_addr equal rd_en/rd_addr delayed 4 cycles throughout → exactly 64 wr_en pulses per stage; no rd_en and wr_en overlap across a stage boundary.
- Sequence conf 1→3→2 (held levels, each change after the prior done) → passes in that order; done_flag 01, 11, 10; bf_mode 1, 2, 0; conf=3 and conf=2 each 70 cycles.
- conf=1 held after done → no restart (busy stays 0 for 100 cycles). conf=4, then conf=1 → pass restarts and done_flag clears to 00 on clear.
- conf=4 asserted at cnt=20 of stage 1 → next cycle IDLE, rd_en=0, wr_en=0 immediately and thereafter, done_flag=00.
- rst=1 at cnt=30 → next cycle all outputs 0; after release with conf=1 held, a full pass restarts (last_conf was cleared).
